led_fade_scheduler: RTL
=======================

Name: led_fade_scheduler

Overview:
Sequences the brightness of the PWM LED stage from occupancy and ambient light, and arbitrates between automatic control and a manual override requester. Produces a duty command and enable for the PWM datapath, with soft fade-in/fade-out, a post-motion hold timer and light-threshold hysteresis. Sits between the sensor inputs (motion, 10-bit light sensor) and the PWM generator.

Parameters:
STEP_CYCLES, 50_000, clk cycles per fade/hold tick (1 ms at 50 MHz)
HOLD_STEPS, 5000, ticks the LED stays on after motion ends
DARK_TH, 300, light_sensor below this sets dark
BRIGHT_TH, 600, light_sensor above this clears dark (must be > DARK_TH)
MAX_DUTY, 255, full-on duty (8-bit)
FADE_STEP, 1, duty change per tick while fading

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
motion  input  1  occupancy sensor, asynchronous
light_sensor  input  10  ambient light level, higher = brighter
ovr_req  input  1  manual override request (level), asynchronous
ovr_duty  input  8  override duty, sampled while ovr_ack=1
ovr_ack  output  1  override granted
duty  output  8  duty command to PWM stage
led_en  output  1  duty != 0
busy  output  1  FADE_IN or FADE_OUT active
state  output  3  current FSM state (debug)

Behaviour:
- rst=0: immediately duty=0, led_en=0, ovr_ack=0, busy=0, state=IDLE, tick counter=0, hold counter=0, dark=0, synchronisers cleared.
- motion and ovr_req pass through 2-flop synchronisers (motion_s, ovr_s); input-to-FSM latency 2 cycles, FSM reacts on the 3rd edge.
- Tick: counter 0..STEP_CYCLES-1, 1-cycle tick pulse on wrap; free-running, never reset by state changes.
- dark: set when light_sensor < DARK_TH, cleared when light_sensor > BRIGHT_TH, otherwise held; updated every cycle.
- Duty arithmetic saturating: up clamps at MAX_DUTY, down clamps at 0; no wrap.
- FSM (encodings 0-4):
  IDLE: duty=0. ovr_s -> OVERRIDE; else motion_s && dark -> FADE_IN.
  FADE_IN: on tick duty += FADE_STEP; duty==MAX_DUTY -> HOLD (hold counter=HOLD_STEPS); !dark -> FADE_OUT.
  HOLD: motion_s reloads hold counter each cycle; else decrement on tick; counter==0 && !motion_s -> FADE_OUT; !dark -> FADE_OUT.
  FADE_OUT: on tick duty -= FADE_STEP; duty==0 -> IDLE; motion_s && dark -> FADE_IN from current duty.
  OVERRIDE: ovr_ack=1, duty=ovr_duty registered each cycle; !ovr_s -> FADE_OUT from current duty, ovr_ack=0 same edge.
- Priority: ovr_s beats all other transitions from any non-OVERRIDE state; then !dark; then motion.
- ovr_ack, led_en, busy registered, consistent with state/duty on the same edge.
- Reset mid-fade or mid-override: no completion, outputs cleared at once.

Decomposition:
- Shared package/include led_ctrl_pkg: state localparams (IDLE, FADE_IN, HOLD, FADE_OUT, OVERRIDE), DUTY_W=8, LIGHT_W=10.
- One sub-module: led_tick_gen (STEP_CYCLES counter, tick output); hysteresis and FSM stay in the top.

Test Plan (STEP_CYCLES=4, HOLD_STEPS=3, MAX_DUTY=8, FADE_STEP=1, DARK_TH=300, BRIGHT_TH=600):
1. light=200, motion=1 after reset -> FADE_IN on 3rd edge, duty 1..8 one per tick, HOLD when duty=8, busy=0, led_en=1.
2. In HOLD, light 200->450 -> stays HOLD; ->650 -> FADE_OUT; back to 450 with motion=1 -> keeps fading out to 0, IDLE (dark stays 0).
3. In HOLD, motion 1->0 -> HOLD for 3 ticks (~12 cycles) then FADE_OUT; motion pulse at tick 2 reloads counter, timeout restarts.
4. During FADE_IN at duty=3, ovr_req=1, ovr_duty=5 -> OVERRIDE within 3 cycles, ovr_ack=1, duty=5; ovr_duty=0 -> duty=0, led_en=0; release -> FADE_OUT, ovr_ack=0.
5. FADE_OUT at duty=4, light=200, motion=1 -> FADE_IN, duty 4->5 on next tick, never 0.
6. rst=0 asynchronously mid-FADE_IN at duty=6 -> duty=0, state=IDLE, led_en=0 before next clk edge; release -> IDLE until motion resynchronised.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared state encoding, bus widths and saturating duty helpers for the LED fade scheduler.
package led_ctrl_pkg;

  localparam int DUTY_W  = 8;
  localparam int LIGHT_W = 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FADE_IN  = 3'd1,
    HOLD     = 3'd2,
    FADE_OUT = 3'd3,
    OVERRIDE = 3'd4
  } led_state_t;

  // Widen by one bit so d + step cannot wrap before the clamp compare.
  function automatic logic [DUTY_W-1:0] duty_up(input logic [DUTY_W-1:0] d,
                                                input logic [DUTY_W-1:0] step,
                                                input logic [DUTY_W-1:0] lim);
    logic [DUTY_W:0] sum;
    sum = {1'b0, d} + {1'b0, step};
    duty_up = (sum >= {1'b0, lim}) ? lim : sum[DUTY_W-1:0];
  endfunction

  function automatic logic [DUTY_W-1:0] duty_down(input logic [DUTY_W-1:0] d,
                                                  input logic [DUTY_W-1:0] step);
    duty_down = (d <= step) ? '0 : d - step;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running STEP_CYCLES divider; tick is high for exactly one cycle as the count wraps.
// No backpressure; the count ignores everything except reset.
module led_tick_gen #(
  parameter int STEP_CYCLES = 50_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/led_fade_scheduler.sv
// LED brightness sequencer: motion/light driven fade-in, hold, fade-out, plus manual override.
// Sensor inputs reach the FSM after a 2-flop synchroniser (acts on 3rd edge); no backpressure.
module led_fade_scheduler
  import led_ctrl_pkg::*;
#(
  parameter int STEP_CYCLES = 50_000,
  parameter int HOLD_STEPS  = 5000,
  parameter int DARK_TH     = 300,
  parameter int BRIGHT_TH   = 600,
  parameter int MAX_DUTY    = 255,
  parameter int FADE_STEP   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               motion,
  input  logic [LIGHT_W-1:0] light_sensor,
  input  logic               ovr_req,
  input  logic [DUTY_W-1:0]  ovr_duty,
  output logic               ovr_ack,
  output logic [DUTY_W-1:0]  duty,
  output logic               led_en,
  output logic               busy,
  output logic [2:0]         state
);
  localparam int HOLD_W = $clog2(HOLD_STEPS + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_STEPS);
  localparam logic [DUTY_W-1:0]  DUTY_MAX   = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0]  DUTY_STEP  = DUTY_W'(FADE_STEP);
  localparam logic [LIGHT_W-1:0] DARK_LVL   = LIGHT_W'(DARK_TH);
  localparam logic [LIGHT_W-1:0] BRIGHT_LVL = LIGHT_W'(BRIGHT_TH);

  logic              motion_m, motion_s;
  logic              ovr_m, ovr_s;
  logic              tick;
  logic              dark;
  led_state_t        state_q, state_d;
  logic [DUTY_W-1:0] duty_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  led_tick_gen #(.STEP_CYCLES(STEP_CYCLES)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Between the two thresholds dark keeps its last value (hysteresis band).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      motion_m <= 1'b0;
      motion_s <= 1'b0;
      ovr_m    <= 1'b0;
      ovr_s    <= 1'b0;
      dark     <= 1'b0;
    end else begin
      motion_m <= motion;
      motion_s <= motion_m;
      ovr_m    <= ovr_req;
      ovr_s    <= ovr_m;
      if (light_sensor < DARK_LVL)        dark <= 1'b1;
      else if (light_sensor > BRIGHT_LVL) dark <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty;
    hold_d  = hold_q;
    if (ovr_s && (state_q != OVERRIDE)) begin
      state_d = OVERRIDE;
      duty_d  = ovr_duty;
    end else begin
      unique case (state_q)
        IDLE: begin
          duty_d = '0;
          if (motion_s && dark) state_d = FADE_IN;
        end
        FADE_IN: begin
          if (!dark) begin
            state_d = FADE_OUT;
          end else if (tick) begin
            duty_d = duty_up(duty, DUTY_STEP, DUTY_MAX);
            if (duty_d == DUTY_MAX) begin
              state_d = HOLD;
              hold_d  = HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          if (!dark)               state_d = FADE_OUT;
          else if (motion_s)       hold_d  = HOLD_LOAD;
          else if (hold_q == '0)   state_d = FADE_OUT;
          else if (tick)           hold_d  = hold_q - 1'b1;
        end
        FADE_OUT: begin
          // Re-entering FADE_IN keeps the current duty so the LED never blinks off.
          if (motion_s && dark) begin
            state_d = FADE_IN;
          end else if (duty == '0) begin
            state_d = IDLE;
          end else if (tick) begin
            duty_d = duty_down(duty, DUTY_STEP);
            if (duty_d == '0) state_d = IDLE;
          end
        end
        OVERRIDE: begin
          if (!ovr_s) state_d = FADE_OUT;
          else        duty_d  = ovr_duty;
        end
        default: begin
          state_d = IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  // Status flags are decoded from the next-state values so they change on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      duty    <= '0;
      hold_q  <= '0;
      ovr_ack <= 1'b0;
      led_en  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      duty    <= duty_d;
      hold_q  <= hold_d;
      ovr_ack <= (state_d == OVERRIDE);
      led_en  <= (duty_d != '0);
      busy    <= (state_d == FADE_IN) || (state_d == FADE_OUT);
    end
  end

  assign state = state_q;

endmodule
